pipeline_stall_sequencer: RTL

//  Sequences stalls, bubbles and flushes for the 5-stage MIPS pipeline. Sits beside the ID stage.

---
 rtl/pipeline_stall_sequencer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/pipeline_stall_sequencer.sv
// Stall/bubble/flush sequencer for a 5-stage MIPS pipeline.
// Arbitrates dmem-busy, load-use and beq hazards onto pipeline enables.
module pipeline_stall_sequencer #(
    parameter int BR_TIMEOUT = 3,
    parameter int CNT_W      = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_id_ex_mem_read,
    input  logic [4:0]       i_id_ex_rt,
    input  logic [31:0]      i_if_id_instr,
    input  logic             i_branch_resolved,
    input  logic             i_branch_taken,
    input  logic             i_dmem_busy,
    output logic             o_pc_write,
    output logic             o_if_id_write,
    output logic             o_id_ex_bubble,
    output logic             o_if_id_flush,
    output logic             o_pipe_hold,
    output logic             o_pc_sel_target,
    output logic [1:0]       o_state,
    output logic [CNT_W-1:0] o_stall_count,
    output logic             o_br_timeout
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_RESUME = 2'd2
    } state_e;

    localparam int TW = (BR_TIMEOUT > 1) ? $clog2(BR_TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'(BR_TIMEOUT - 1);

    state_e           state_q;
    logic [TW-1:0]    tcnt_q;
    logic             taken_q;
    logic [CNT_W-1:0] cnt_q;
    logic             to_q;

    logic ld_use;
    logic is_beq;

    // Hazard decode of the instruction sitting in IF/ID
    always_comb begin
        ld_use = i_id_ex_mem_read && (i_id_ex_rt != 5'd0) &&
                 ((i_id_ex_rt == i_if_id_instr[25:21]) ||
                  (i_id_ex_rt == i_if_id_instr[20:16]));
        is_beq = (i_if_id_instr[31:26] == 6'b000100);
    end

    // Same-cycle enable generation; everything low while in reset
    always_comb begin
        o_pc_write      = 1'b0;
        o_if_id_write   = 1'b0;
        o_id_ex_bubble  = 1'b0;
        o_if_id_flush   = 1'b0;
        o_pipe_hold     = 1'b0;
        o_pc_sel_target = 1'b0;
        if (!i_rst_n) begin
            o_pc_write = 1'b0;
        end else if (i_dmem_busy) begin
            o_pipe_hold = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ld_use) begin
                        o_id_ex_bubble = 1'b1;
                    end else if (is_beq) begin
                        o_if_id_write = 1'b1;
                        o_if_id_flush = 1'b1;
                    end else begin
                        o_pc_write    = 1'b1;
                        o_if_id_write = 1'b1;
                    end
                end
                S_WAIT: begin
                    o_if_id_write = 1'b1;
                    o_if_id_flush = 1'b1;
                end
                S_RESUME: begin
                    o_pc_write      = 1'b1;
                    o_if_id_write   = 1'b1;
                    o_if_id_flush   = 1'b1;
                    o_pc_sel_target = taken_q;
                end
                default: begin
                    o_pc_write = 1'b0;
                end
            endcase
        end
    end

    // Sequencer state, branch wait timer and stall statistics
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            tcnt_q  <= '0;
            taken_q <= 1'b0;
            cnt_q   <= '0;
            to_q    <= 1'b0;
        end else begin
            if (!o_pc_write && !(&cnt_q)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (!i_dmem_busy) begin
                case (state_q)
                    S_IDLE: begin
                        if (!ld_use && is_beq) begin
                            state_q <= S_WAIT;
                            tcnt_q  <= '0;
                        end
                    end
                    S_WAIT: begin
                        if (i_branch_resolved) begin
                            taken_q <= i_branch_taken;
                            state_q <= S_RESUME;
                        end else if (tcnt_q == T_LAST) begin
                            to_q    <= 1'b1;
                            taken_q <= 1'b0;
                            state_q <= S_RESUME;
                        end else begin
                            tcnt_q <= tcnt_q + TW'(1);
                        end
                    end
                    S_RESUME: begin
                        state_q <= S_IDLE;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_state       = state_q;
    assign o_stall_count = cnt_q;
    assign o_br_timeout  = to_q;

endmodule
